pattern_detector: RTL
=====================

// Module: pattern_detector
// PURPOSE
//   Parametrised Mealy-style serial pattern detector: shifts one input bit per enabled
//   clock into a WIDTH-bit window and compares it against two programmable patterns.
//   Match flags are registered, and saturating per-pattern match counters are kept.
//   Next generation of the fixed 3-bit detector: width/patterns parametrised, plus
//   enable, overlap mode, window-fill qualification, counters and reset.
// PARAMETERS
//   WIDTH  3       window length in bits (>=2)
//   PAT_A  3'b001  pattern A (WIDTH bits); match drives o[1]
//   PAT_B  3'b111  pattern B (WIDTH bits); match drives o[0]
//   CNT_W  8       width of each match counter
// PORTS
//   clock      in   1      single clock, all state updates on posedge
//   reset      in   1      synchronous, active-high reset
//   en         in   1      sample i this cycle
//   i          in   1      serial data bit; newest bit enters window[0]
//   overlap    in   1      1: overlapping matches; 0: window restarts after a match
//   clear_cnt  in   1      synchronous clear of both counters
//   o          out  2      {matchA, matchB}, registered, one cycle per match
//   count_a    out  CNT_W  saturating count of pattern-A matches
//   count_b    out  CNT_W  saturating count of pattern-B matches
// BEHAVIOUR
//   - State: window[WIDTH-1:0]; fill counter 0..WIDTH (number of valid bits in window).
//   - reset=1 at posedge: window=0, fill=0, o=2'b00, count_a=0, count_b=0. Overrides all inputs.
//   - en=1 (no reset): window'={window[WIDTH-2:0], i}; fill'=min(fill+1, WIDTH).
//     If fill'==WIDTH: hitA=(window'==PAT_A), hitB=(window'==PAT_B), else both 0.
//     o <= {hitA, hitB} in that same edge (zero-cycle latency from the sampled bit).
//     No match is reported before WIDTH bits have been sampled since reset.
//   - PAT_A==PAT_B: both o bits are set and both counters increment.
//   - overlap=0 and (hitA|hitB): fill' forced to 0; the next match needs WIDTH fresh bits.
//     overlap=1: fill stays WIDTH; consecutive-cycle matches are allowed.
//     overlap is sampled each edge; a change takes effect on that edge.
//   - en=0: window and fill hold; o <= 2'b00; counters hold (except for clear_cnt).
//   - Counters: +1 on each hit, saturating at 2^CNT_W-1 (no wrap).
//     clear_cnt=1: both counters become 0 on that edge. Clear wins over a simultaneous
//     hit, but o still reports the hit.
//   - Reset mid-stream discards a partial window; detection restarts from fill=0.
// TESTING (WIDTH=3, defaults unless stated; one bit per enabled clock)
//   1. Reset, overlap=1, bits 1,1,1,0,0,1,1,0,0,1 -> o: 00,00,01,00,00,10,00,00,00,10;
//      count_a=2, count_b=1.
//   2. overlap=1, six 1s -> o=01 on bits 3,4,5,6, count_b=4;
//      overlap=0, six 1s -> o=01 on bits 3 and 6 only, count_b=2.
//   3. en toggling: bits 0,0 / en=0 for 3 clocks / bit 1 -> o=00 while en=0, o=10 on
//      the bit-1 edge (window held).
//   4. CNT_W=2, overlap=1, seven 1s -> count_b saturates at 3;
//      clear_cnt on a match edge -> count_b=0 while o=01.
//   5. Reset mid-stream after bits 0,0 -> next bit 1 gives o=00 (fill=1);
//      1,1 afterwards gives no 111 until the 3rd post-reset 1 -> o=01.
//   6. WIDTH=5, PAT_A=5'b10110, PAT_B=5'b10110 -> sequence 1,0,1,1,0 -> o=11 on bit 5;
//      both counters =1.

Source files
------------

// File: rtl/pattern_detector.sv
// Serial pattern detector with two programmable patterns.
// The WIDTH-bit window shifts in one bit per enabled clock. Match flags are
// registered in the same edge that samples the completing bit. A saturating
// counter is kept for each pattern.
module pattern_detector #(
  parameter int unsigned      WIDTH = 3,
  parameter logic [WIDTH-1:0] PAT_A = WIDTH'(3'b001),
  parameter logic [WIDTH-1:0] PAT_B = WIDTH'(3'b111),
  parameter int unsigned      CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             i,
  input  logic             overlap,
  input  logic             clear_cnt,
  output logic [1:0]       o,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
);

  localparam int unsigned       FILL_W    = $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [WIDTH-1:0]  window;
  logic [FILL_W-1:0] fill;

  logic [WIDTH-1:0]  window_nxt_c;
  logic [FILL_W-1:0] fill_inc_c;
  logic [FILL_W-1:0] fill_nxt_c;
  logic              hit_a_c;
  logic              hit_b_c;

  // Next window/fill and match detection on the window after this edge's shift
  always_comb begin
    window_nxt_c = window;
    fill_inc_c   = fill;
    fill_nxt_c   = fill;
    hit_a_c      = 1'b0;
    hit_b_c      = 1'b0;
    if (en) begin
      window_nxt_c = {window[WIDTH-2:0], i};
      fill_inc_c   = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
      if (fill_inc_c == FILL_FULL) begin
        hit_a_c = (window_nxt_c == PAT_A);
        hit_b_c = (window_nxt_c == PAT_B);
      end
      // Non-overlapping mode: a match consumes the whole window
      fill_nxt_c = (!overlap && (hit_a_c || hit_b_c)) ? '0 : fill_inc_c;
    end
  end

  // Window, fill level and registered match flags
  always_ff @(posedge clock) begin
    if (reset) begin
      window <= '0;
      fill   <= '0;
      o      <= 2'b00;
    end else begin
      window <= window_nxt_c;
      fill   <= fill_nxt_c;
      o      <= {hit_a_c, hit_b_c};
    end
  end

  // Saturating match counters; clear wins over a simultaneous hit
  always_ff @(posedge clock) begin
    if (reset || clear_cnt) begin
      count_a <= '0;
      count_b <= '0;
    end else begin
      if (hit_a_c && (count_a != CNT_MAX)) count_a <= count_a + CNT_W'(1);
      if (hit_b_c && (count_b != CNT_MAX)) count_b <= count_b + CNT_W'(1);
    end
  end

endmodule
